// File: rtl/io_initiator.sv
// io_initiator: single-outstanding initiator for the stb/we/addr/data/ack IO bus,
// with a held response port and a timeout that reports the faulting address.
module io_initiator #(
  parameter int AW = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          stb,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [31:0]   data_out,
  input  logic [31:0]   data_in,
  input  logic          ack,
  output logic          err_sig,
  output logic [AW-1:0] err_addr
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          expire;
  assign req_ready = state == IDLE;
  assign expire = TIMEOUT != 0 && cnt == LAST;
  // rst is active-low; ack outside BUS is ignored because stb is only high in BUS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stb       <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_sig   <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_sig <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we       <= req_we;
          addr     <= req_addr;
          data_out <= req_we ? req_wdata : 32'd0;
          cnt      <= '0;
          stb      <= 1'b1;
          state    <= BUS;
        end
        BUS: if (ack) begin
          rsp_rdata <= we ? 32'd0 : data_in;
          rsp_err   <= 1'b0;
          stb       <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else if (expire) begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b1;
          stb       <= 1'b0;
          rsp_valid <= 1'b1;
          err_sig   <= 1'b1;
          err_addr  <= addr;
          state     <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_initiator.sv
// tb_io_initiator: scoreboard bench for io_initiator with a wait-state device model.
module tb_io_initiator;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        stb, we, ack, err_sig;
  logic [3:0]  addr, err_addr;
  logic [31:0] data_out, data_in;
  int          checks = 0;
  int          errors = 0;
  int          ws = 0;
  logic        ack_en = 1'b0;
  logic [7:0]  scnt = 8'd0;
  int          errc = 0;
  logic        err_prev = 1'b0;
  int          errc_base;
  logic        exp_we;
  logic [3:0]  exp_addr;
  logic [31:0] exp_do;
  logic [3:0]  cur_ea = 4'd0;
  typedef struct {logic [31:0] rd; logic err;} exp_t;
  exp_t sb[$];

  io_initiator #(.AW(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .stb(stb), .we(we), .addr(addr), .data_out(data_out),
    .data_in(data_in), .ack(ack), .err_sig(err_sig), .err_addr(err_addr)
  );

  always #5 clk = ~clk;
  // device acks combinationally on the (ws+1)-th stb cycle
  always @(posedge clk) scnt <= stb ? scnt + 8'd1 : 8'd0;
  assign ack = ack_en && stb && scnt == 8'(ws);

  always @(negedge clk) begin
    if (err_sig) errc++;
    check("err_consec", {31'd0, err_sig & err_prev}, 32'd0);
    err_prev = err_sig;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input int wsv, input logic ae,
                      input bit push, input logic e);
    int n;
    exp_t x;
    ws = wsv; ack_en = ae; data_in = rd;
    exp_we = w; exp_addr = a; exp_do = w ? d : 32'd0;
    x.rd = (w || e) ? 32'd0 : rd; x.err = e;
    if (push) sb.push_back(x);
    errc_base = errc;
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("acc_wait", n, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic collect(input int exp_stb, input int exp_lat, input int hold, input bit bp);
    int lat, stbc;
    exp_t x;
    lat = 1; stbc = 0;
    while (!rsp_valid && lat < 100) begin
      if (stb) begin
        stbc++;
        check("bus_we", {31'd0, we}, {31'd0, exp_we});
        check("bus_addr", {28'd0, addr}, {28'd0, exp_addr});
        check("bus_data", data_out, exp_do);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("stb_cycles", stbc, exp_stb);
    if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      x = sb.pop_front();
      if (x.err) cur_ea = exp_addr;
      check("rsp_rdata", rsp_rdata, x.rd);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, x.err});
      if (bp) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 32'h0BADF00D; end
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_rdata", rsp_rdata, x.rd);
        check("hold_err", {31'd0, rsp_err}, {31'd0, x.err});
        check("hold_ready", {31'd0, req_ready}, 32'd0);
        check("hold_stb", {31'd0, stb}, 32'd0);
        check("hold_addr", {28'd0, addr}, {28'd0, exp_addr});
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_done", {31'd0, rsp_valid}, 32'd0);
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("err_pulses", errc - errc_base, {31'd0, x.err});
      check("err_addr", {28'd0, err_addr}, {28'd0, cur_ea});
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 4'd0;
    req_wdata = 32'd0; rsp_ready = 1'b0; data_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_errsig", {31'd0, err_sig}, 32'd0);
    check("rst_erraddr", {28'd0, err_addr}, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    send(1'b1, 4'd2, 32'hDEADBEEF, 32'hFFFF0000, 0, 1'b1, 1'b1, 1'b0);
    collect(1, 2, 0, 1'b0);
    send(1'b0, 4'd6, 32'h11111111, 32'h12345678, 3, 1'b1, 1'b1, 1'b0);
    collect(4, 5, 0, 1'b0);
    send(1'b0, 4'd5, 32'd0, 32'hAAAA5555, 0, 1'b0, 1'b1, 1'b1);
    collect(4, 5, 0, 1'b0);
    send(1'b0, 4'd7, 32'd0, 32'hCAFEF00D, 3, 1'b1, 1'b1, 1'b0);
    collect(4, 5, 1, 1'b0);
    send(1'b0, 4'd9, 32'd0, 32'h55AA55AA, 1, 1'b1, 1'b1, 1'b0);
    collect(2, 3, 10, 1'b1);
    send(1'b1, 4'd3, 32'h0BADF00D, 32'h0, 0, 1'b1, 1'b1, 1'b0);
    collect(1, 2, 0, 1'b0);
    send(1'b0, 4'd8, 32'd0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_stb", {31'd0, stb}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check("arst_stb", {31'd0, stb}, 32'd0);
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_errsig", {31'd0, err_sig}, 32'd0);
    @(posedge clk); #4;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("post_rst_stb", {31'd0, stb}, 32'd0);
    end
    cur_ea = 4'd0;
    send(1'b0, 4'd1, 32'd0, 32'h87654321, 2, 1'b1, 1'b1, 1'b0);
    collect(3, 4, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
